// File: rtl/pacman_pkg.sv
// Shared types for the Pac-Man motion controller: direction encoding, FSM states
// and animation frame indices.
package pacman_pkg;

  typedef enum logic [1:0] {
    DIR_R = 2'd0,
    DIR_U = 2'd1,
    DIR_D = 2'd2,
    DIR_L = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MOVE  = 2'd1,
    DYING = 2'd2,
    DEAD  = 2'd3
  } state_t;

  localparam logic [1:0] FRAME_OPEN   = 2'd0;
  localparam logic [1:0] FRAME_HALF   = 2'd1;
  localparam logic [1:0] FRAME_CLOSED = 2'd2;

  // The encoding pairs opposites as bitwise complements: R<->L, U<->D.
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(~d);
  endfunction

endpackage

// File: rtl/pacman_anim_seq.sv
// Mouth animation sequencer: divides enabled ticks by DIV and steps the frame
// index through the ping-pong sequence OPEN, HALF, CLOSED, HALF, OPEN, ...
module pacman_anim_seq
  import pacman_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       enable,
  input  logic       hold,
  output logic [1:0] frame
);

  localparam int CW = $clog2(DIV + 1);

  logic [CW-1:0] cnt;
  logic          rising;

  // NOTE: sequential state is written with <= only, so every register samples
  // the pre-edge values of its neighbours regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      rising <= 1'b1;
      frame  <= FRAME_OPEN;
    end else if (clear) begin
      cnt    <= '0;
      rising <= 1'b1;
      frame  <= FRAME_OPEN;
    end else if (enable && !hold) begin
      if (cnt == CW'(DIV - 1)) begin
        cnt <= '0;
        if (rising) begin
          if (frame == FRAME_CLOSED) begin
            frame  <= FRAME_HALF;
            rising <= 1'b0;
          end else begin
            frame <= frame + 2'd1;
          end
        end else begin
          if (frame == FRAME_OPEN) begin
            frame  <= FRAME_HALF;
            rising <= 1'b1;
          end else begin
            frame <= frame - 2'd1;
          end
        end
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/pacman_motion.sv
// Per-frame Pac-Man controller: owns position, facing, life state and animation,
// advancing once per frame_tick from joystick, wall and ghost-catch inputs.
module pacman_motion
  import pacman_pkg::*;
#(
  parameter logic [8:0] X_INIT      = 9'd112,
  parameter logic [8:0] Y_INIT      = 9'd188,
  parameter logic [8:0] X_MIN       = 9'd7,
  parameter logic [8:0] X_MAX       = 9'd216,
  parameter int         STEP_DIV    = 2,
  parameter int         ANIM_DIV    = 4,
  parameter int         DEATH_TICKS = 90
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       game_start,
  input  logic       joy_valid,
  input  logic [1:0] joy_dir,
  input  logic [3:0] blocked,
  input  logic       caught,
  output logic [8:0] xloc,
  output logic [8:0] yloc,
  output logic [1:0] pacman_dir,
  output logic       pacman_alive,
  output logic [1:0] animation_cycle,
  output logic       death_done
);

  localparam int SW = $clog2(STEP_DIV + 1);
  localparam int DW = $clog2(DEATH_TICKS + 1);

  state_t        state;
  dir_t          dir;
  dir_t          pending;
  logic [SW-1:0] step_cnt;
  logic [DW-1:0] death_cnt;

  dir_t       eff_dir;
  dir_t       next_dir;
  logic       move_tick;
  logic       go;
  logic [8:0] next_x;
  logic [8:0] next_y;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    eff_dir   = joy_valid ? dir_t'(joy_dir) : pending;
    move_tick = (step_cnt == SW'(STEP_DIV - 1));
    next_dir  = dir;
    next_x    = xloc;
    next_y    = yloc;
    // Turns wait for a move tick; an unblocked reversal is honoured at once.
    if (!blocked[eff_dir] && (move_tick || eff_dir == opposite(dir)))
      next_dir = eff_dir;
    go = move_tick && !blocked[next_dir];
    case (next_dir)
      DIR_R: next_x = (xloc == X_MAX) ? X_MIN : xloc + 9'd1;
      DIR_L: next_x = (xloc == X_MIN) ? X_MAX : xloc - 9'd1;
      DIR_U: next_y = yloc - 9'd1;
      DIR_D: next_y = yloc + 9'd1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      dir          <= DIR_R;
      pending      <= DIR_R;
      xloc         <= X_INIT;
      yloc         <= Y_INIT;
      pacman_alive <= 1'b1;
      death_done   <= 1'b0;
      step_cnt     <= '0;
      death_cnt    <= '0;
    end else begin
      if (joy_valid) pending <= dir_t'(joy_dir);
      case (state)
        IDLE: if (game_start) state <= MOVE;
        MOVE: begin
          if (caught) begin
            state        <= DYING;
            pacman_alive <= 1'b0;
            death_cnt    <= '0;
          end else if (frame_tick) begin
            dir      <= next_dir;
            step_cnt <= move_tick ? '0 : step_cnt + SW'(1);
            if (go) begin
              xloc <= next_x;
              yloc <= next_y;
            end
          end
        end
        DYING: begin
          if (frame_tick) begin
            if (death_cnt == DW'(DEATH_TICKS - 1)) begin
              state      <= DEAD;
              death_done <= 1'b1;
              death_cnt  <= '0;
            end else begin
              death_cnt <= death_cnt + DW'(1);
            end
          end
        end
        DEAD: begin
          if (game_start) begin
            state        <= MOVE;
            xloc         <= X_INIT;
            yloc         <= Y_INIT;
            dir          <= DIR_R;
            pacman_alive <= 1'b1;
            death_done   <= 1'b0;
            step_cnt     <= '0;
            death_cnt    <= '0;
          end
        end
      endcase
    end
  end

  assign pacman_dir = dir;

  // Animation only runs while moving; a wall stall freezes it mid-sequence.
  pacman_anim_seq #(
    .DIV (ANIM_DIV)
  ) u_anim (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  ((state != MOVE) || caught),
    .enable ((state == MOVE) && frame_tick),
    .hold   (blocked[next_dir]),
    .frame  (animation_cycle)
  );

endmodule
